// File: rtl/lut_access_ctrl.sv
// lut_access_ctrl
//   Owns the single access port of a 2**AW-entry LUT storage array.
//   After reset, or when clr_req is seen in RUN, the array is cleared with
//   an address sweep that lasts exactly DEPTH cycles.  Outside the sweep, one
//   write requester and one read requester share the port round-robin using
//   valid/ready handshakes.  Read data is registered, so responses arrive
//   one cycle after the read grant.
//
//   Optional feature macro: LUT_POPCNT_EN adds pop_cnt, a running count of
//   nonzero entries.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   wr_valid/ready/addr/data
//                         write request channel; ready is combinational
//   rd_valid/ready/addr   read request channel; ready is combinational
//   rsp_valid, rsp_data   read response, a 1-cycle pulse; data holds otherwise
//   clr_req               request a clear sweep (acted on in RUN only)
//   busy                  high while sweeping (INIT or CLR)
//   mem_we/addr/wdata     memory port drive (combinational)
//   mem_rdata             asynchronous memory read data at mem_addr
//   pop_cnt               (LUT_POPCNT_EN only) count of entries != 0
module lut_access_ctrl #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    input  logic          clr_req,
    output logic          busy,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef LUT_POPCNT_EN
    output logic [AW:0]   pop_cnt,
`endif
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_CLR
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] ptr;
    logic          rr_wr;   // 1: write side wins the next contested cycle

    assign busy = (state != ST_RUN);

    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        rd_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            ST_INIT, ST_CLR: begin
                mem_we   = 1'b1;
                mem_addr = ptr;
                if (ptr == LAST_ADDR) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A clear request takes the cycle; neither side is granted.
                if (clr_req) begin
                    state_next = ST_CLR;
                end else if (wr_valid && (!rd_valid || rr_wr)) begin
                    wr_ready  = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end else if (rd_valid) begin
                    rd_ready = 1'b1;
                    mem_addr = rd_addr;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            ptr       <= '0;
            rr_wr     <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state <= state_next;
            // ptr wraps from LAST_ADDR back to 0 as the sweep finishes, so a
            // later CLR sweep always starts at address 0.
            if (state != ST_RUN) begin
                ptr <= ptr + AW'(1);
            end
            if (wr_ready) begin
                rr_wr <= 1'b0;
            end else if (rd_ready) begin
                rr_wr <= 1'b1;
            end
            rsp_valid <= rd_ready;
            if (rd_ready) begin
                rsp_data <= mem_rdata;
            end
        end
    end

`ifdef LUT_POPCNT_EN
    logic [AW:0] pop_inc;
    logic [AW:0] pop_dec;

    // During a write grant mem_addr == wr_addr, so mem_rdata is the value
    // being overwritten.
    assign pop_inc = {{AW{1'b0}}, (wr_data != '0)};
    assign pop_dec = {{AW{1'b0}}, (mem_rdata != '0)};

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_cnt <= '0;
        end else if (state != ST_RUN || clr_req) begin
            pop_cnt <= '0;
        end else if (wr_ready) begin
            pop_cnt <= pop_cnt + pop_inc - pop_dec;
        end
    end
`endif

endmodule

// File: tb/tb_lut_access_ctrl.sv
module tb_lut_access_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 1;
    localparam int unsigned DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          clr_req;
    logic          busy;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef LUT_POPCNT_EN
    logic [AW:0]   pop_cnt;
`endif

    int unsigned checks;
    int unsigned failures;

    logic [DW-1:0] mem [DEPTH];

    lut_access_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .clr_req   (clr_req),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef LUT_POPCNT_EN
        .pop_cnt   (pop_cnt),
`endif
        .mem_rdata (mem_rdata)
    );

    // Storage array behind the controller: async read, sync write.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reset for one edge, then let the 16-cycle INIT sweep run out.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (DEPTH) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_valid = 1'b0;
        rd_addr  = '0;
        clr_req  = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 1'b1;

        // 1: reset values, then the INIT sweep
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            check("init_busy", busy, 1);
            check("init_we", mem_we, 1);
            check("init_addr", mem_addr, i);
            check("init_wdata", mem_wdata, 0);
            @(negedge clk);
            #1;
        end
        check("init_done_busy", busy, 0);
        check("run_idle_we", mem_we, 0);

        // 2: write 5 <- 1, then read 5
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 1'b1;
        #1;
        check("t2_wr_ready", wr_ready, 1);
        check("t2_wr_we", mem_we, 1);
        check("t2_wr_addr", mem_addr, 5);
        check("t2_wr_wdata", mem_wdata, 1);
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd5;
        #1;
        check("t2_rd_ready", rd_ready, 1);
        check("t2_rd_we", mem_we, 0);
        check("t2_rd_addr", mem_addr, 5);
        check("t2_rsp_early", rsp_valid, 0);
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_data", rsp_data, 1);
        check("t2_idle_addr", mem_addr, 0);
        check("t2_idle_wdata", mem_wdata, 0);
        @(negedge clk);
        #1;
        check("t2_rsp_drop", rsp_valid, 0);
        check("t2_rsp_hold", rsp_data, 1);

        // 3: both valid held high, alternating grants starting with write
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 1'b1;
            rd_valid = 1'b1; rd_addr = 4'd3;
            #1;
            check("t3_wr_ready", wr_ready, (i % 2 == 0));
            check("t3_rd_ready", rd_ready, (i % 2 == 1));
            check("t3_rsp_valid", rsp_valid, (i > 0 && i % 2 == 0));
            if (i > 0 && i % 2 == 0) check("t3_rsp_data", rsp_data, 1);
        end

        // 4: fill with ones, clear sweep, then all reads return 0
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 1'b1; rd_valid = 1'b0;
            #1;
            check("t4_fill_ready", wr_ready, 1);
        end
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd9;
        #1;
`ifdef LUT_POPCNT_EN
        check("t4_pop_full", pop_cnt, DEPTH);
`endif
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        check("t4_pre_rsp_valid", rsp_valid, 1);
        check("t4_pre_rsp_data", rsp_data, 1);
        @(negedge clk);
        clr_req = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
        #1;
        check("t4_clr_wr_ready", wr_ready, 0);
        check("t4_clr_rd_ready", rd_ready, 0);
        check("t4_clr_busy", busy, 0);
        check("t4_clr_we", mem_we, 0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            clr_req = (i < 8);
            #1;
            check("t4_sw_busy", busy, 1);
            check("t4_sw_wr_ready", wr_ready, 0);
            check("t4_sw_rd_ready", rd_ready, 0);
            check("t4_sw_we", mem_we, 1);
            check("t4_sw_addr", mem_addr, i);
            check("t4_sw_wdata", mem_wdata, 0);
`ifdef LUT_POPCNT_EN
            if (i == 0) check("t4_pop_clr", pop_cnt, 0);
`endif
        end
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            clr_req = 1'b0; wr_valid = 1'b0;
            rd_valid = (i < DEPTH); rd_addr = AW'(i);
            #1;
            if (i < DEPTH) check("t4_rd_ready", rd_ready, 1);
            if (i > 0) begin
                check("t4_rsp_valid", rsp_valid, 1);
                check("t4_rsp_data", rsp_data, 0);
            end
        end

        // 5: reset drops a pending response; reset mid-sweep restarts at 0
        @(negedge clk);
        rd_valid = 1'b1; rd_addr = 4'd0; rst = 1'b1;
        #1;
        check("t5_rd_ready", rd_ready, 1);
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        check("t5_rsp_dropped", rsp_valid, 0);
        check("t5_busy", busy, 1);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            #1;
        end
        check("t5_addr7", mem_addr, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            check("t5_busy_sweep", busy, 1);
            check("t5_addr", mem_addr, i);
            @(negedge clk);
            #1;
        end
        check("t5_busy_done", busy, 0);

`ifdef LUT_POPCNT_EN
        // 6: population count through writes and a clear
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            case (i)
                0: begin wr_addr = 4'd2; wr_data = 1'b1; end
                1: begin wr_addr = 4'd7; wr_data = 1'b1; end
                2: begin wr_addr = 4'd9; wr_data = 1'b1; end
                default: begin wr_addr = 4'd7; wr_data = 1'b0; end
            endcase
            #1;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        check("t6_pop", pop_cnt, 2);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        check("t6_pop_clr", pop_cnt, 0);
        check("t6_busy", busy, 1);
        repeat (DEPTH) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
